// File: rtl/i2c_target_regif.sv
// ============================================================================
// Module   : i2c_target_regif
// Purpose  : I2C target that answers to DEV_ADDR, with a register-file port
//            offering a pointer, write strobes and auto-incrementing reads.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_target_regif #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       rd_nack
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  // Synchronisers reset to the idle-bus level so reset release never looks like an edge.
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_q, sda_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_sync[SYNC_STAGES-1];
      sda_q    <= sda_sync[SYNC_STAGES-1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;
  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start_c  = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_c   = scl_s & scl_q & ~sda_q & sda_s;

  state_t     state;
  logic [7:0] shreg;
  logic [3:0] bitcnt;
  logic       rw, ptr_phase, ack_phase, inc_pend;
  logic [7:0] byte_in;
  assign byte_in = {shreg[6:0], sda_s};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      shreg     <= 8'h00;
      bitcnt    <= 4'd0;
      rw        <= 1'b0;
      ptr_phase <= 1'b0;
      ack_phase <= 1'b0;
      inc_pend  <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= 8'h00;
      wr_data   <= 8'h00;
      wr_valid  <= 1'b0;
      rd_req    <= 1'b0;
      busy      <= 1'b0;
      rd_nack   <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      rd_req   <= 1'b0;
      rd_nack  <= 1'b0;
      if (start_c) begin
        state     <= ADDR;
        bitcnt    <= 4'd0;
        busy      <= 1'b1;
        sda_oe    <= 1'b0;
        ack_phase <= 1'b0;
      end else if (stop_c) begin
        state  <= IDLE;
        bitcnt <= 4'd0;
        busy   <= 1'b0;
        sda_oe <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg  <= byte_in;
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt == 4'd7) begin
              bitcnt    <= 4'd0;
              rw        <= sda_s;
              ack_phase <= 1'b0;
              state     <= (byte_in[7:1] == DEV_ADDR) ? ADDR_ACK : WAIT_STOP;
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe    <= 1'b1;
              ack_phase <= 1'b1;
              rd_req    <= rw;
            end else begin
              ack_phase <= 1'b0;
              if (rw) begin
                // The first read bit goes out on the same fall that ends the ACK.
                sda_oe <= ~shreg[7];
                shreg  <= {shreg[6:0], 1'b0};
                bitcnt <= 4'd1;
                state  <= RD_BYTE;
              end else begin
                sda_oe    <= 1'b0;
                bitcnt    <= 4'd0;
                ptr_phase <= 1'b1;
                state     <= WR_BYTE;
              end
            end
          end
          WR_BYTE: if (scl_rise) begin
            shreg  <= byte_in;
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt == 4'd7) begin
              bitcnt    <= 4'd0;
              ack_phase <= 1'b0;
              state     <= WR_ACK;
              if (ptr_phase) begin
                reg_addr  <= byte_in;
                ptr_phase <= 1'b0;
                inc_pend  <= 1'b0;
              end else begin
                wr_data  <= byte_in;
                wr_valid <= 1'b1;
                inc_pend <= 1'b1;
              end
            end
          end
          WR_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              sda_oe    <= 1'b0;
              ack_phase <= 1'b0;
              inc_pend  <= 1'b0;
              if (inc_pend) reg_addr <= reg_addr + 8'd1;
              state <= WR_BYTE;
            end
          end
          RD_BYTE: if (scl_fall) begin
            if (bitcnt == 4'd8) begin
              sda_oe <= 1'b0;
              bitcnt <= 4'd0;
              state  <= RD_ACK;
            end else begin
              sda_oe <= ~shreg[7];
              shreg  <= {shreg[6:0], 1'b0};
              bitcnt <= bitcnt + 4'd1;
            end
          end
          RD_ACK: if (scl_rise) begin
            if (!sda_s) begin
              reg_addr <= reg_addr + 8'd1;
              rd_req   <= 1'b1;
              bitcnt   <= 4'd0;
              state    <= RD_BYTE;
            end else begin
              rd_nack <= 1'b1;
              state   <= WAIT_STOP;
            end
          end
          default: ;
        endcase
        // rd_data is valid the clock after rd_req; no SCL edge can coincide with it.
        if (rd_req) shreg <= rd_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_target_regif.sv
// ============================================================================
// Module   : tb_i2c_target_regif
// Purpose  : Bus-level I2C master driving i2c_target_regif, checked against a
//            pointer/register-file reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_i2c_target_regif;

  localparam int Q = 6;  // clocks per quarter SCL period

  logic       clk = 1'b0, resetn = 1'b0, scl = 1'b1, sda_m = 1'b1;
  logic [7:0] rd_data = 8'h00;
  logic       sda_oe, wr_valid, rd_req, busy, rd_nack;
  logic [7:0] reg_addr, wr_data;
  wire        sda_bus = sda_m & ~sda_oe;

  i2c_target_regif #(.DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn), .scl_i(scl), .sda_i(sda_bus), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .wr_data(wr_data), .wr_valid(wr_valid), .rd_req(rd_req),
    .rd_data(rd_data), .busy(busy), .rd_nack(rd_nack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] mem [256];
  logic [7:0] model_ptr = 8'h00;
  logic [7:0] buf_d [8];
  logic [7:0] exp_wa[$], exp_wd[$], exp_ra[$], got_wa[$], got_wd[$], got_ra[$];
  int nack_cnt = 0, exp_nack = 0, viol = 0, oe_cycles = 0;
  logic oe_prev = 1'b0;

  // Register-file responder and bus observers.
  always @(negedge clk) begin
    if (wr_valid) begin
      got_wa.push_back(reg_addr);
      got_wd.push_back(wr_data);
    end
    if (rd_req) begin
      got_ra.push_back(reg_addr);
      rd_data = mem[reg_addr];
    end else begin
      rd_data = 8'($urandom);
    end
    if (rd_nack) nack_cnt++;
    if (sda_oe) oe_cycles++;
    if (sda_oe !== oe_prev && scl) viol++;
    oe_prev = sda_oe;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q); scl = 1'b1; tick(Q); sda_m = 1'b0; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q); scl = 1'b1; tick(Q); sda_m = 1'b1; tick(Q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; tick(Q); scl = 1'b1; tick(2*Q); scl = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; tick(Q); scl = 1'b1; tick(Q); b = sda_bus; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(~ack);
  endtask

  task automatic write_txn(input logic [7:0] p, input int n, input logic do_stop);
    logic ack;
    bus_start();
    check("busy_start", busy, 1);
    send_byte(8'hA0, ack);  check("ack_addr_w", ack, 1);
    send_byte(p, ack);      check("ack_ptr", ack, 1);
    model_ptr = p;
    for (int i = 0; i < n; i++) begin
      exp_wa.push_back(model_ptr);
      exp_wd.push_back(buf_d[i]);
      send_byte(buf_d[i], ack);
      check("ack_data", ack, 1);
      model_ptr = model_ptr + 8'd1;
    end
    if (do_stop) begin
      bus_stop();
      check("busy_stop", busy, 0);
    end
    check("reg_addr_w", reg_addr, model_ptr);
  endtask

  // Reads n bytes, ACKing all but the last; the pointer advances only on master ACK.
  task automatic read_txn(input int n);
    logic ack;
    logic [7:0] d;
    bus_start();
    check("busy_start_r", busy, 1);
    send_byte(8'hA1, ack);
    check("ack_addr_r", ack, 1);
    for (int i = 0; i < n; i++) begin
      exp_ra.push_back(model_ptr);
      recv_byte(d, i < n - 1);
      check("rd_byte", d, mem[model_ptr]);
      if (i < n - 1) model_ptr = model_ptr + 8'd1;
    end
    exp_nack++;
    bus_stop();
    check("busy_stop_r", busy, 0);
    check("reg_addr_r", reg_addr, model_ptr);
  endtask

  task automatic mismatch_txn(input logic [6:0] dev, input logic rw);
    logic ack;
    oe_cycles = 0;
    bus_start();
    check("busy_mm", busy, 1);
    send_byte({dev, rw}, ack);
    check("nack_addr", ack, 0);
    if (!rw) begin
      send_byte(8'($urandom), ack);
      check("nack_data", ack, 0);
    end
    bus_stop();
    check("busy_mm_stop", busy, 0);
    check("oe_mm", oe_cycles, 0);
    check("reg_addr_mm", reg_addr, model_ptr);
  endtask

  task automatic flush_check();
    check("n_wr", got_wa.size(), exp_wa.size());
    for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
      check("wr_addr", got_wa[i], exp_wa[i]);
      check("wr_data", got_wd[i], exp_wd[i]);
    end
    check("n_rdreq", got_ra.size(), exp_ra.size());
    for (int i = 0; i < exp_ra.size() && i < got_ra.size(); i++)
      check("rdreq_addr", got_ra[i], exp_ra[i]);
    check("n_rd_nack", nack_cnt, exp_nack);
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
    got_wa.delete(); got_wd.delete(); got_ra.delete();
  endtask

  initial begin
    logic ack;
    int   n;
    logic [6:0] dev;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    tick(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_pulses", {wr_valid, rd_req, rd_nack}, 0);
    resetn = 1'b1;
    tick(5);

    // Plain multi-byte write.
    buf_d[0] = 8'h5A; buf_d[1] = 8'hC3;
    write_txn(8'h10, 2, 1'b1);
    flush_check();

    // Reset mid-address, then reset while the address ACK is being driven.
    bus_start();
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
    resetn = 1'b0; #1;
    check("rstmid_sda_oe", sda_oe, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_reg_addr", reg_addr, 0);
    model_ptr = 8'h00;
    tick(2); resetn = 1'b1;
    sda_m = 1'b1; tick(Q); scl = 1'b1; tick(2*Q);
    bus_start();
    for (int i = 7; i >= 0; i--) put_bit(i == 7 || i == 5);
    sda_m = 1'b1; tick(Q);
    check("ack_drive", sda_oe, 1);
    resetn = 1'b0; #1;
    check("rstack_sda_oe", sda_oe, 0);
    tick(2); resetn = 1'b1;
    sda_m = 1'b1; tick(Q); scl = 1'b1; tick(2*Q);
    flush_check();

    // Pointer write, repeated START, read ACK then NACK.
    mem[8'h20] = 8'h3C; mem[8'h21] = 8'h96;
    write_txn(8'h20, 0, 1'b0);
    read_txn(2);
    flush_check();

    mismatch_txn(7'h58, 1'b0);
    flush_check();

    // Pointer wraps from 0xFF to 0x00.
    buf_d[0] = 8'h01; buf_d[1] = 8'h02;
    write_txn(8'hFF, 2, 1'b1);
    flush_check();

    // STOP in the middle of a data byte, then a fresh transaction.
    bus_start();
    send_byte(8'hA0, ack); check("t6_ack_a", ack, 1);
    send_byte(8'h10, ack); check("t6_ack_p", ack, 1);
    model_ptr = 8'h10;
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
    bus_stop();
    check("t6_busy", busy, 0);
    flush_check();
    bus_start();
    send_byte(8'hA0, ack); check("t6_ack_again", ack, 1);
    bus_stop();
    check("t6_reg_addr", reg_addr, model_ptr);
    flush_check();

    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          n = $urandom_range(1, 4);
          for (int i = 0; i < n; i++) buf_d[i] = 8'($urandom);
          write_txn(8'($urandom), n, 1'b1);
        end
        1: begin
          write_txn(8'($urandom), 0, 1'b0);
          read_txn($urandom_range(1, 4));
        end
        2: read_txn($urandom_range(1, 3));
        default: begin
          dev = 7'($urandom);
          if (dev == 7'h50) dev = 7'h51;
          mismatch_txn(dev, 1'($urandom));
        end
      endcase
      flush_check();
    end

    check("oe_while_scl_high", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
